// File: rtl/udp_port_filter.sv
// UDP header/payload filter: forwards frames whose destination port matches MATCH_PORT and drops
// frames with a short length field or another port. Define UDP_PORT_FILTER_STATS_EN to add pass/drop counters.
module udp_port_filter #(
   parameter logic [15:0] MATCH_PORT     = 16'd51820,
   parameter logic [15:0] MIN_UDP_LENGTH = 16'd8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_udp_hdr_valid,
   output logic        s_udp_hdr_ready,
   input  logic [31:0] s_ip_source_ip,
   input  logic [31:0] s_ip_dest_ip,
   input  logic [15:0] s_udp_source_port,
   input  logic [15:0] s_udp_dest_port,
   input  logic [15:0] s_udp_length,
   input  logic [15:0] s_udp_checksum,
   input  logic [7:0]  s_udp_payload_axis_tdata,
   input  logic        s_udp_payload_axis_tvalid,
   output logic        s_udp_payload_axis_tready,
   input  logic        s_udp_payload_axis_tlast,
   input  logic        s_udp_payload_axis_tuser,
   output logic        m_udp_hdr_valid,
   input  logic        m_udp_hdr_ready,
   output logic [31:0] m_ip_source_ip,
   output logic [31:0] m_ip_dest_ip,
   output logic [15:0] m_udp_source_port,
   output logic [15:0] m_udp_dest_port,
   output logic [15:0] m_udp_length,
   output logic [15:0] m_udp_checksum,
   output logic [7:0]  m_udp_payload_axis_tdata,
   output logic        m_udp_payload_axis_tvalid,
   input  logic        m_udp_payload_axis_tready,
   output logic        m_udp_payload_axis_tlast,
   output logic        m_udp_payload_axis_tuser,
   output logic        error_bad_length
`ifdef UDP_PORT_FILTER_STATS_EN
   ,
   output logic [31:0] pass_count,
   output logic [31:0] drop_count
`endif
);

   typedef enum logic [1:0] {IDLE, HDR, PASS, DROP} state_t;

   state_t state, state_next;
   logic   hdr_fire, len_bad, port_ok;

   assign hdr_fire = s_udp_hdr_valid && s_udp_hdr_ready;
   assign len_bad  = s_udp_length < MIN_UDP_LENGTH;
   assign port_ok  = (MATCH_PORT == 16'd0) || (s_udp_dest_port == MATCH_PORT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next                = state;
      // Header ready is gated by reset so every output reads zero while rst_n is low.
      s_udp_hdr_ready           = rst_n && (state == IDLE);
      m_udp_hdr_valid           = (state == HDR);
      s_udp_payload_axis_tready = 1'b0;
      m_udp_payload_axis_tdata  = 8'd0;
      m_udp_payload_axis_tvalid = 1'b0;
      m_udp_payload_axis_tlast  = 1'b0;
      m_udp_payload_axis_tuser  = 1'b0;
      case (state)
         IDLE: begin
            if (hdr_fire) begin
               if (len_bad)      state_next = DROP;
               else if (port_ok) state_next = HDR;
               else              state_next = DROP;
            end
         end
         HDR: begin
            if (m_udp_hdr_ready) state_next = PASS;
         end
         PASS: begin
            m_udp_payload_axis_tdata  = s_udp_payload_axis_tdata;
            m_udp_payload_axis_tvalid = s_udp_payload_axis_tvalid;
            m_udp_payload_axis_tlast  = s_udp_payload_axis_tlast;
            m_udp_payload_axis_tuser  = s_udp_payload_axis_tuser;
            s_udp_payload_axis_tready = m_udp_payload_axis_tready;
            if (s_udp_payload_axis_tvalid && m_udp_payload_axis_tready && s_udp_payload_axis_tlast)
               state_next = IDLE;
         end
         DROP: begin
            s_udp_payload_axis_tready = 1'b1;
            if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Fields are captured only on acceptance, so they stay stable through HDR and PASS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ip_source_ip    <= 32'd0;
         m_ip_dest_ip      <= 32'd0;
         m_udp_source_port <= 16'd0;
         m_udp_dest_port   <= 16'd0;
         m_udp_length      <= 16'd0;
         m_udp_checksum    <= 16'd0;
         error_bad_length  <= 1'b0;
      end else begin
         error_bad_length <= hdr_fire && len_bad;
         if (hdr_fire) begin
            m_ip_source_ip    <= s_ip_source_ip;
            m_ip_dest_ip      <= s_ip_dest_ip;
            m_udp_source_port <= s_udp_source_port;
            m_udp_dest_port   <= s_udp_dest_port;
            m_udp_length      <= s_udp_length;
            m_udp_checksum    <= s_udp_checksum;
         end
      end
   end

`ifdef UDP_PORT_FILTER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_count <= 32'd0;
         drop_count <= 32'd0;
      end else if (hdr_fire) begin
         if (!len_bad && port_ok) begin
            if (pass_count != 32'hFFFF_FFFF) pass_count <= pass_count + 32'd1;
         end else begin
            if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_udp_port_filter.sv
// Randomized self-checking bench for udp_port_filter; a frame-level model predicts forwarded headers,
// bytes and error pulses. Counter checks are compiled in when UDP_PORT_FILTER_STATS_EN is defined.
module tb_udp_port_filter;
   localparam logic [15:0] MATCH = 16'd51820;
   localparam logic [15:0] MINL  = 16'd8;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        s_udp_hdr_valid, s_udp_hdr_ready;
   logic [31:0] s_ip_source_ip, s_ip_dest_ip;
   logic [15:0] s_udp_source_port, s_udp_dest_port, s_udp_length, s_udp_checksum;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tready, s_tlast, s_tuser;
   logic        m_udp_hdr_valid, m_udp_hdr_ready;
   logic [31:0] m_ip_source_ip, m_ip_dest_ip;
   logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tready, m_tlast, m_tuser;
   logic        error_bad_length;
`ifdef UDP_PORT_FILTER_STATS_EN
   logic [31:0] pass_count, drop_count;
`endif

   udp_port_filter #(.MATCH_PORT(MATCH), .MIN_UDP_LENGTH(MINL)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
      .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
      .s_udp_source_port(s_udp_source_port), .s_udp_dest_port(s_udp_dest_port),
      .s_udp_length(s_udp_length), .s_udp_checksum(s_udp_checksum),
      .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tvalid(s_tvalid),
      .s_udp_payload_axis_tready(s_tready), .s_udp_payload_axis_tlast(s_tlast),
      .s_udp_payload_axis_tuser(s_tuser),
      .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
      .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
      .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
      .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
      .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tvalid(m_tvalid),
      .m_udp_payload_axis_tready(m_tready), .m_udp_payload_axis_tlast(m_tlast),
      .m_udp_payload_axis_tuser(m_tuser),
      .error_bad_length(error_bad_length)
`ifdef UDP_PORT_FILTER_STATS_EN
      , .pass_count(pass_count), .drop_count(drop_count)
`endif
   );

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model state: expected/observed header {dest,len} and beat {tuser,tlast,data} streams.
   logic [31:0] exp_hdrs[$], got_hdrs[$];
   logic [9:0]  exp_beats[$], got_beats[$];
   int exp_pass = 0, exp_drop = 0, exp_err = 0, got_err = 0, err_run = 0;
   int rdy_mode = 0;   // 0 random, 1 always ready, 2 toggle
   bit no_gaps = 0;
   bit in_pass = 0;
   int last_hdr_wait = 0;
   logic        hdr_rdy_s, s_tready_s, hdr_v_s, err_s;
   logic [15:0] dport_s, len_s;
   logic [31:0] sip_s;

   // One cycle: set sink readies, settle, sample what transfers at the coming posedge.
   task automatic tick();
      case (rdy_mode)
         1:       begin m_udp_hdr_ready = 1'b1; m_tready = 1'b1; end
         2:       begin m_udp_hdr_ready = 1'b1; m_tready = ~m_tready; end
         default: begin
            m_udp_hdr_ready = ($urandom_range(99) < 70);
            m_tready        = ($urandom_range(99) < 70);
         end
      endcase
      #1;
      hdr_rdy_s = s_udp_hdr_ready; s_tready_s = s_tready; hdr_v_s = m_udp_hdr_valid;
      err_s = error_bad_length; dport_s = m_udp_dest_port; len_s = m_udp_length; sip_s = m_ip_source_ip;
      if (!in_pass) chk("m_tvalid_outside_pass", m_tvalid, 1'b0);
      else          chk("s_tready_mirror", s_tready, m_tready);
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
         got_hdrs.push_back({m_udp_dest_port, m_udp_length});
         in_pass = 1;
      end
      if (m_tvalid && m_tready) begin
         got_beats.push_back({m_tuser, m_tlast, m_tdata});
         if (m_tlast) in_pass = 0;
      end
      if (error_bad_length) begin
         got_err++; err_run++;
      end else begin
         if (err_run != 0) chk("err_pulse_width", err_run, 1);
         err_run = 0;
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [15:0] dport, input logic [15:0] len, input int nb,
                             input int kill_beat);
      bit          pass, first;
      logic [31:0] sip;
      logic [7:0]  d[8];
      logic        u[8];
      int          i, t;
      pass  = (len >= MINL) && ((MATCH == 16'd0) || (dport == MATCH));
      sip   = $urandom;
      for (int k = 0; k < 8; k++) begin d[k] = 8'($urandom); u[k] = 1'($urandom); end
      s_udp_hdr_valid = 1'b1; s_udp_dest_port = dport; s_udp_length = len; s_ip_source_ip = sip;
      s_ip_dest_ip = $urandom; s_udp_source_port = 16'($urandom); s_udp_checksum = 16'($urandom);
      t = 0;
      forever begin
         tick();
         if (hdr_rdy_s) break;
         if (++t > 200) begin chk("hdr_accept_timeout", 0, 1); s_udp_hdr_valid = 1'b0; return; end
      end
      last_hdr_wait = t;
      s_udp_hdr_valid = 1'b0;
      // Scramble the inputs so a design that fails to register them is caught.
      s_udp_dest_port = 16'($urandom); s_udp_length = 16'($urandom); s_ip_source_ip = $urandom;
      if (pass) begin exp_pass++; exp_hdrs.push_back({dport, len}); end
      else exp_drop++;
      if (len < MINL) exp_err++;
      i = 0; t = 0; first = 1;
      while (i < nb) begin
         if (i == kill_beat) return;
         s_tvalid = no_gaps ? 1'b1 : ($urandom_range(3) != 0);
         s_tdata = d[i]; s_tlast = (i == nb - 1); s_tuser = u[i];
         tick();
         if (first) begin
            first = 0;
            chk("hdr_valid_latency", hdr_v_s, pass);
            chk("err_pulse_cycle", err_s, len < MINL);
            if (pass) begin
               chk("hdr_dest_port", dport_s, dport);
               chk("hdr_length", len_s, len);
               chk("hdr_source_ip", sip_s, sip);
            end
         end
         if (!pass && s_tvalid) chk("drop_tready", s_tready_s, 1'b1);
         if (s_tvalid && s_tready_s) begin
            if (pass) exp_beats.push_back({u[i], (i == nb - 1), d[i]});
            i++; t = 0;
         end else if (++t > 300) begin
            chk("beat_timeout", 0, 1); s_tvalid = 1'b0; return;
         end
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic compare_and_flush();
      int n;
      chk("hdr_count", got_hdrs.size(), exp_hdrs.size());
      n = (got_hdrs.size() < exp_hdrs.size()) ? got_hdrs.size() : exp_hdrs.size();
      for (int k = 0; k < n; k++) chk("hdr_stream", got_hdrs[k], exp_hdrs[k]);
      chk("beat_count", got_beats.size(), exp_beats.size());
      n = (got_beats.size() < exp_beats.size()) ? got_beats.size() : exp_beats.size();
      for (int k = 0; k < n; k++) chk("beat_stream", got_beats[k], exp_beats[k]);
      chk("err_pulse_count", got_err, exp_err);
`ifdef UDP_PORT_FILTER_STATS_EN
      chk("pass_count", pass_count, exp_pass);
      chk("drop_count", drop_count, exp_drop);
`endif
      got_hdrs.delete(); exp_hdrs.delete(); got_beats.delete(); exp_beats.delete();
      got_err = 0; exp_err = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; s_udp_hdr_valid = 1'b0;
      #1;
      chk("rst_hdr_ready", s_udp_hdr_ready, 1'b0);
      chk("rst_hdr_valid", m_udp_hdr_valid, 1'b0);
      chk("rst_m_tvalid", m_tvalid, 1'b0);
      chk("rst_m_tdata", m_tdata, 8'd0);
      chk("rst_s_tready", s_tready, 1'b0);
      chk("rst_err", error_bad_length, 1'b0);
      chk("rst_dest_port", m_udp_dest_port, 16'd0);
      chk("rst_length", m_udp_length, 16'd0);
      @(negedge clk);
      s_tvalid = 1'b0; s_tlast = 1'b0;
      in_pass = 0; err_run = 0; exp_pass = 0; exp_drop = 0;
      got_hdrs.delete(); exp_hdrs.delete(); got_beats.delete(); exp_beats.delete();
      got_err = 0; exp_err = 0;
      @(negedge clk);
`ifdef UDP_PORT_FILTER_STATS_EN
      chk("rst_pass_count", pass_count, 32'd0);
      chk("rst_drop_count", drop_count, 32'd0);
`endif
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      s_udp_hdr_valid = 0; s_ip_source_ip = 0; s_ip_dest_ip = 0; s_udp_source_port = 0;
      s_udp_dest_port = 0; s_udp_length = 0; s_udp_checksum = 0;
      s_tdata = 0; s_tvalid = 0; s_tlast = 0; s_tuser = 0; m_udp_hdr_ready = 0; m_tready = 0;
      @(negedge clk);
      do_reset();
      // Directed: pass, wrong port, short length.
      rdy_mode = 1;
      send_frame(16'd51820, 16'd12, 4, -1);
      send_frame(16'd53, 16'd12, 4, -1);
      send_frame(16'd51820, 16'd7, 3, -1);
      send_frame(16'd51820, 16'd8, 2, -1);
      repeat (2) tick();
      compare_and_flush();
      // Sink toggling on every cycle.
      rdy_mode = 2; m_tready = 1'b1;
      send_frame(16'd51820, 16'd20, 6, -1);
      repeat (2) tick();
      compare_and_flush();
      // Randomized frames.
      rdy_mode = 0;
      for (int f = 0; f < 40; f++) begin
         logic [15:0] p, l;
         case ($urandom_range(3))
            0, 1:    p = MATCH;
            2:       p = 16'd53;
            default: p = 16'($urandom);
         endcase
         case ($urandom_range(4))
            0:       l = 16'd7;
            1:       l = 16'd8;
            2:       l = 16'd0;
            default: l = 16'($urandom_range(40));
         endcase
         send_frame(p, l, $urandom_range(1, 8), -1);
      end
      repeat (3) tick();
      compare_and_flush();
      // Reset on the second payload beat of a passing frame, then a frame right after release.
      rdy_mode = 1;
      send_frame(16'd51820, 16'd12, 4, 1);
      s_tvalid = 1'b1; s_tdata = 8'h02; s_tlast = 1'b0;
      do_reset();
      send_frame(16'd51820, 16'd12, 4, -1);
      chk("first_hdr_after_reset", last_hdr_wait, 0);
      repeat (2) tick();
      compare_and_flush();
      // Back-to-back pass, drop, pass with no idle cycles.
      @(negedge clk);
      do_reset();
      no_gaps = 1;
      send_frame(16'd51820, 16'd16, 5, -1);
      send_frame(16'd1234, 16'd16, 3, -1);
      chk("zero_gap_hdr_drop", last_hdr_wait, 0);
      send_frame(16'd51820, 16'd9, 4, -1);
      chk("zero_gap_hdr_pass", last_hdr_wait, 0);
      repeat (2) tick();
      chk("b2b_pass_model", exp_pass, 2);
      compare_and_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
